regfile_mp: RTL

Parametrised multi-port register file, the next generation of the single-cycle CPU register file, for the dual-issue/pipelined datapath.
- Storage: 2**ADDR_W entries of DATA_W bits.
- Ports: NUM_RD registered read ports and NUM_WR write ports.
- Options: hardwired zero register and write-to-read bypass.
- Placement: sits between decode (read addresses) and writeback (write ports).

---
 rtl/cpu_pkg.sv | 12 +
 rtl/rf_read_port.sv | 55 +++++
 rtl/regfile_mp.sv | 72 +++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the pipelined core's register file and its port counts.
package cpu_pkg;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;
  localparam logic [4:0]  REG_ZERO  = 5'd0;

  // Dual-issue core: two instructions each reading two sources, two writebacks.
  localparam int unsigned RF_NUM_RD = 4;
  localparam int unsigned RF_NUM_WR = 2;

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: zero-register override, write-first bypass mux and
// an enabled output register with asynchronous clear.
module rf_read_port
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned NUM_WR   = 1,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic [DATA_W-1:0]        entry_data,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  // Ascending scan so the highest matching write port overrides lower ones.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      if (ZERO_REG && (rd_addr == ADDR_W'(REG_ZERO))) begin
        rd_data_d = '0;
      end else begin
        rd_data_d = entry_data;
        if (BYPASS) begin
          for (int unsigned j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == rd_addr)) begin
              rd_data_d = wr_data[j*DATA_W +: DATA_W];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: storage array with highest-port-wins write
// resolution, feeding NUM_RD independent registered read ports.
module regfile_mp
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 1,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_entry [NUM_RD];

  // Later (higher-index) ports overwrite earlier ones on an address conflict.
  always_comb begin
    mem_d = mem_q;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      if (wr_en[j] &&
          !(ZERO_REG && (wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(REG_ZERO)))) begin
        mem_d[wr_addr[j*ADDR_W +: ADDR_W]] = wr_data[j*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    assign rd_entry[i] = mem_q[rd_addr[i*ADDR_W +: ADDR_W]];

    rf_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_WR   (NUM_WR),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rd_port (
      .clk        (clk),
      .rst        (rst),
      .rd_en      (rd_en[i]),
      .rd_addr    (rd_addr[i*ADDR_W +: ADDR_W]),
      .entry_data (rd_entry[i]),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_data    (rd_data[i*DATA_W +: DATA_W])
    );
  end

endmodule
